// File: rtl/hpdcache_ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// hpdcache_ram_arb_pkg
//   Shared types and helpers for the 1RW SRAM arbiter.
//   - arb_state_e   : INIT (zero-fill sweep) / RUN (serving requesters)
//   - arb_cnt_width : counter/pointer width, $clog2(n) with a minimum of 1
// -----------------------------------------------------------------------------
package hpdcache_ram_arb_pkg;

    typedef enum logic {ARB_INIT, ARB_RUN} arb_state_e;

    function automatic int unsigned arb_cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hpdcache_rrarb.sv
// -----------------------------------------------------------------------------
// hpdcache_rrarb
//   Combinational round-robin arbiter with a registered priority pointer.
//   The search starts at the pointer and rotates upward modulo NREQ. After a
//   grant to g the pointer moves to (g+1) mod NREQ; with no grant it holds.
// Ports
//   clk_i   in   clock
//   rst_ni  in   asynchronous active-low reset (pointer -> 0)
//   req_i   in   NREQ  candidate vector
//   en_i    in   grant enable (no grant and no pointer update when low)
//   gnt_o   out  NREQ  one-hot or zero grant
// -----------------------------------------------------------------------------
module hpdcache_rrarb
    import hpdcache_ram_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o
);

    localparam int unsigned PTR_W = arb_cnt_width(NREQ);
    localparam logic [PTR_W:0] NREQ_EXT = (PTR_W + 1)'(NREQ);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W:0]   sum;
    logic [PTR_W:0]   nxt;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        sum   = '0;
        nxt   = '0;
        idx   = '0;
        if (en_i) begin
            for (int k = 0; k < int'(NREQ); k++) begin
                // Rotated index (ptr + k) mod NREQ, computed one bit wider
                // so the wrap compare cannot overflow.
                sum = {1'b0, ptr_q} + (PTR_W + 1)'(k);
                if (sum >= NREQ_EXT) begin
                    sum = sum - NREQ_EXT;
                end
                idx = PTR_W'(sum);
                if (!found && req_i[idx]) begin
                    found      = 1'b1;
                    gnt_o[idx] = 1'b1;
                    nxt        = {1'b0, idx} + 1'b1;
                    ptr_d      = (nxt == NREQ_EXT) ? '0 : PTR_W'(nxt);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/hpdcache_ram_1rw_arbiter.sv
// -----------------------------------------------------------------------------
// hpdcache_ram_1rw_arbiter
//   Shares one 1RW SRAM macro between NREQ requesters using round-robin
//   arbitration. Reads return data one cycle after grant on a shared data bus
//   qualified by a one-hot response valid.
//   Optional feature macro: HPDCACHE_RAM_ARB_INIT_EN
//     defined   : after reset the whole array is zero-written (DEPTH cycles)
//                 before any requester is served.
//     undefined : requesters are served from the first cycle after reset.
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_valid_i/req_ready_o    per-requester handshake (ready one-hot or zero)
//   req_we_i/addr/wdata/wmask  per-requester packed request fields
//   rsp_valid_o/rsp_rdata_o    one-hot read response valid, shared read data
//   ram_*                      SRAM macro interface (registered read data in)
//   init_done_o                high once the array is usable
// -----------------------------------------------------------------------------
module hpdcache_ram_1rw_arbiter
    import hpdcache_ram_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned ADDR_SIZE = 6,
    parameter int unsigned DATA_SIZE = 64,
    parameter int unsigned DEPTH     = 2**ADDR_SIZE
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NREQ-1:0]           req_valid_i,
    output logic [NREQ-1:0]           req_ready_o,
    input  logic [NREQ-1:0]           req_we_i,
    input  logic [NREQ*ADDR_SIZE-1:0] req_addr_i,
    input  logic [NREQ*DATA_SIZE-1:0] req_wdata_i,
    input  logic [NREQ*DATA_SIZE-1:0] req_wmask_i,
    output logic [NREQ-1:0]           rsp_valid_o,
    output logic [DATA_SIZE-1:0]      rsp_rdata_o,
    output logic                      ram_cs_o,
    output logic                      ram_we_o,
    output logic [ADDR_SIZE-1:0]      ram_addr_o,
    output logic [DATA_SIZE-1:0]      ram_wdata_o,
    output logic [DATA_SIZE-1:0]      ram_wmask_o,
    input  logic [DATA_SIZE-1:0]      ram_rdata_i,
    output logic                      init_done_o
);

    // Elaboration-time sanity check of the configuration.
    if (NREQ < 2 || DEPTH == 0 || DEPTH > (2**ADDR_SIZE)) begin : g_bad_cfg
        $error("hpdcache_ram_1rw_arbiter: invalid NREQ/DEPTH configuration");
    end

    logic                 run;
    logic                 init_active;
    logic [ADDR_SIZE-1:0] init_addr;
    logic                 arb_en;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rsp_valid_q;

    // -------------------------------------------------------------------------
    // Optional zero-fill sweep
    // -------------------------------------------------------------------------
`ifdef HPDCACHE_RAM_ARB_INIT_EN
    localparam int unsigned         CNT_W    = arb_cnt_width(DEPTH);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEPTH - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_active = 1'b0;
        case (state_q)
            ARB_INIT: begin
                init_active = 1'b1;
                // The last word is still written; the counter stops there.
                if (cnt_q == CNT_LAST) begin
                    state_d = ARB_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_RUN: begin
                state_d = ARB_RUN;
            end
            default: begin
                state_d = ARB_INIT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign run       = (state_q == ARB_RUN);
    assign init_addr = ADDR_SIZE'(cnt_q);
`else
    assign run         = 1'b1;
    assign init_active = 1'b0;
    assign init_addr   = '0;
`endif

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    // Gating with rst_ni keeps the macro deselected while reset is held.
    assign arb_en = run & rst_ni;

    hpdcache_rrarb #(
        .NREQ (NREQ)
    ) i_rrarb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_valid_i),
        .en_i   (arb_en),
        .gnt_o  (gnt)
    );

    assign req_ready_o = gnt;

    // -------------------------------------------------------------------------
    // One-hot AND-OR request mux
    // -------------------------------------------------------------------------
    logic [NREQ-1:0]                 term_we;
    logic [NREQ-1:0][ADDR_SIZE-1:0]  term_addr;
    logic [NREQ-1:0][DATA_SIZE-1:0]  term_wdata;
    logic [NREQ-1:0][DATA_SIZE-1:0]  term_wmask;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_term
        assign term_we[gi]    = gnt[gi] & req_we_i[gi];
        assign term_addr[gi]  = {ADDR_SIZE{gnt[gi]}} & req_addr_i[gi*ADDR_SIZE +: ADDR_SIZE];
        assign term_wdata[gi] = {DATA_SIZE{gnt[gi]}} & req_wdata_i[gi*DATA_SIZE +: DATA_SIZE];
        assign term_wmask[gi] = {DATA_SIZE{gnt[gi]}} & req_wmask_i[gi*DATA_SIZE +: DATA_SIZE];
    end

    logic                 sel_we;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [DATA_SIZE-1:0] sel_wdata;
    logic [DATA_SIZE-1:0] sel_wmask;

    always_comb begin
        sel_we    = |term_we;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wmask = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            sel_addr  = sel_addr  | term_addr[i];
            sel_wdata = sel_wdata | term_wdata[i];
            sel_wmask = sel_wmask | term_wmask[i];
        end
    end

    assign ram_cs_o    = rst_ni & (init_active | (|gnt));
    assign ram_we_o    = init_active ? 1'b1 : sel_we;
    assign ram_addr_o  = init_active ? init_addr : sel_addr;
    assign ram_wdata_o = init_active ? '0 : sel_wdata;
    assign ram_wmask_o = init_active ? '1 : sel_wmask;

    // -------------------------------------------------------------------------
    // Read response: macro data arrives one cycle after the read grant.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= '0;
        end else begin
            rsp_valid_q <= gnt & ~req_we_i;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = ram_rdata_i;
    assign init_done_o = run;

endmodule

// File: tb/tb_hpdcache_ram_1rw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hpdcache_ram_1rw_arbiter
//   Directed bench for the 1RW SRAM arbiter with a behavioural 1RW SRAM
//   (bit-masked write, registered read). Follows HPDCACHE_RAM_ARB_INIT_EN.
// -----------------------------------------------------------------------------
module tb_hpdcache_ram_1rw_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 6;
    localparam int DW   = 64;

    logic                 clk;
    logic                 rst_ni;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ*DW-1:0]   req_wmask;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 ram_cs;
    logic                 ram_we;
    logic [AW-1:0]        ram_addr;
    logic [DW-1:0]        ram_wdata;
    logic [DW-1:0]        ram_wmask;
    logic [DW-1:0]        ram_rdata;
    logic                 init_done;

    int n_total = 0;
    int n_pass  = 0;

    hpdcache_ram_1rw_arbiter #(
        .NREQ      (NREQ),
        .ADDR_SIZE (AW),
        .DATA_SIZE (DW),
        .DEPTH     (64)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wmask_i (req_wmask),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .ram_cs_o    (ram_cs),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_wmask_o (ram_wmask),
        .ram_rdata_i (ram_rdata),
        .init_done_o (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1RW SRAM
    logic [DW-1:0] mem [64];
    always_ff @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [DW-1:0] wm);
        req_valid[i]           = v;
        req_we[i]              = we;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = wd;
        req_wmask[i*DW +: DW]  = wm;
    endtask

    initial begin
        logic [1:0] exp_gnt;
        rst_ni    = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        repeat (3) step();

        // Reset state
        chk("reset_cs", 64'(ram_cs), 64'd0);
        chk("reset_ready", 64'(req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);

`ifdef HPDCACHE_RAM_ARB_INIT_EN
        // Sweep, interrupted by reset at address 20
        rst_ni = 1'b1;
        set_req(0, 1'b1, 1'b0, 6'd0, '0, '0);
        #1;
        $display("sweep start: addr=%0d init_done=%0b", ram_addr, init_done);
        chk("sweep_init_done_low", 64'(init_done), 64'd0);
        chk("sweep_cs", 64'(ram_cs), 64'd1);
        chk("sweep_we", 64'(ram_we), 64'd1);
        chk("sweep_addr0", 64'(ram_addr), 64'd0);
        chk("sweep_wmask", ram_wmask, {64{1'b1}});
        chk("sweep_ready_blocked", 64'(req_ready), 64'd0);
        repeat (20) step();
        chk("sweep_addr20", 64'(ram_addr), 64'd20);
        rst_ni = 1'b0;
        #1;
        chk("sweep_reset_cs", 64'(ram_cs), 64'd0);
        step();
        rst_ni = 1'b1;
        #1;
        $display("sweep restart: addr=%0d", ram_addr);
        chk("sweep_restart_addr0", 64'(ram_addr), 64'd0);
        repeat (63) step();
        chk("sweep_addr63", 64'(ram_addr), 64'd63);
        chk("sweep_last_init_done_low", 64'(init_done), 64'd0);
        chk("sweep_last_ready_blocked", 64'(req_ready), 64'd0);
        step();
        $display("sweep end: init_done=%0b ready=%b", init_done, req_ready);
        chk("sweep_done", 64'(init_done), 64'd1);
        chk("post_sweep_ready0", 64'(req_ready), 64'd1);
        step();
        set_req(0, 1'b1, 1'b0, 6'd63, '0, '0);
        chk("rd0_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rd0_zero", rsp_rdata, 64'd0);
        #1;
        chk("rd63_ready", 64'(req_ready), 64'd1);
        step();
        set_req(0, 1'b0, 1'b0, 6'd0, '0, '0);
        $display("read addr63: rsp_valid=%b rdata=%0h", rsp_valid, rsp_rdata);
        chk("rd63_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rd63_zero", rsp_rdata, 64'd0);
`else
        // First cycle after reset release is already served
        rst_ni = 1'b1;
        set_req(0, 1'b1, 1'b0, 6'd7, '0, '0);
        #1;
        $display("first cycle: init_done=%0b ready=%b cs=%0b", init_done, req_ready, ram_cs);
        chk("noinit_init_done", 64'(init_done), 64'd1);
        chk("noinit_first_ready", 64'(req_ready), 64'd1);
        chk("noinit_first_cs", 64'(ram_cs), 64'd1);
        step();
        set_req(0, 1'b0, 1'b0, 6'd0, '0, '0);
        chk("noinit_rsp_valid", 64'(rsp_valid), 64'd1);
`endif

        // Write then read back addr 5
        set_req(0, 1'b1, 1'b1, 6'd5, 64'hA5, {64{1'b1}});
        #1;
        $display("wr addr5: ready=%b we=%0b addr=%0d wdata=%0h", req_ready, ram_we, ram_addr, ram_wdata);
        chk("wr5_ready", 64'(req_ready), 64'd1);
        chk("wr5_we", 64'(ram_we), 64'd1);
        chk("wr5_addr", 64'(ram_addr), 64'd5);
        chk("wr5_wdata", ram_wdata, 64'hA5);
        step();
        set_req(0, 1'b1, 1'b0, 6'd5, '0, '0);
        #1;
        chk("wr5_no_rsp", 64'(rsp_valid), 64'd0);
        chk("rd5_ready", 64'(req_ready), 64'd1);
        chk("rd5_we", 64'(ram_we), 64'd0);
        step();
        set_req(0, 1'b0, 1'b0, 6'd0, '0, '0);
        $display("rd addr5: rsp_valid=%b rdata=%0h", rsp_valid, rsp_rdata);
        chk("rd5_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rd5_rdata", rsp_rdata, 64'hA5);

        // Masked write on addr 3
        set_req(0, 1'b1, 1'b1, 6'd3, 64'hFFFF, {64{1'b1}});
        step();
        set_req(0, 1'b1, 1'b1, 6'd3, 64'h0000, 64'h00FF);
        #1;
        chk("mwr_ready", 64'(req_ready), 64'd1);
        chk("mwr_wmask", ram_wmask, 64'h00FF);
        step();
        set_req(0, 1'b1, 1'b0, 6'd3, '0, '0);
        step();
        set_req(0, 1'b0, 1'b0, 6'd0, '0, '0);
        $display("masked rd addr3: rsp_valid=%b rdata=%0h", rsp_valid, rsp_rdata);
        chk("mrd_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("mrd_rdata", rsp_rdata, 64'hFF00);

        // Only req1 for 3 cycles, then both: alternate starting with req0
        set_req(1, 1'b1, 1'b0, 6'd9, '0, '0);
        for (int k = 0; k < 3; k++) begin
            #1;
            $display("solo req1 cycle %0d: ready=%b", k, req_ready);
            chk("solo1_ready", 64'(req_ready), 64'd2);
            step();
        end
        set_req(0, 1'b1, 1'b0, 6'd10, '0, '0);
        for (int k = 0; k < 6; k++) begin
            exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            $display("contended cycle %0d: ready=%b", k, req_ready);
            chk("rr_ready", 64'(req_ready), 64'(exp_gnt));
            step();
            chk("rr_rsp_valid", 64'(rsp_valid), 64'(exp_gnt));
        end

        // Reset with a read in flight; pointer must return to 0
        set_req(1, 1'b0, 1'b0, 6'd0, '0, '0);
        #1;
        chk("pre_rst_ready", 64'(req_ready), 64'd1);
        step();
        rst_ni = 1'b0;
        #1;
        $display("mid reset: rsp_valid=%b cs=%0b ready=%b", rsp_valid, ram_cs, req_ready);
        chk("midrst_rsp_lost", 64'(rsp_valid), 64'd0);
        chk("midrst_cs", 64'(ram_cs), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd0);
        set_req(1, 1'b1, 1'b0, 6'd11, '0, '0);
        step();
        rst_ni = 1'b1;
`ifdef HPDCACHE_RAM_ARB_INIT_EN
        repeat (64) step();
        chk("resweep_done", 64'(init_done), 64'd1);
`endif
        #1;
        $display("after reset: ready=%b", req_ready);
        chk("post_rst_ptr0", 64'(req_ready), 64'd1);
        step();
        req_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
